regfile_param: RTL and testbench
================================

# regfile_param

Parametrised general-purpose register file, successor to the fixed 8x32 register bank, placed between instruction decode and the ALU. It provides NRD combinational read ports plus a dedicated branch-target read port, two independent write ports (ALU result and decode/immediate) that can both fire in the same cycle, and a per-register pending scoreboard. The scoreboard lets decode stall on registers awaiting a multi-cycle result. An optional write-to-read bypass is compiled in by macro.

## Interface
- DW, 32, data width in bits
- NREG, 8, number of registers; power of two, 2..64
- AW, $clog2(NREG), address width; derived, do not override
- NRD, 2, number of general read ports, 1..4
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- rd_addr  in  NRD*AW  read addresses; port i at bits [i*AW +: AW]
- rd_data  out  NRD*DW  read data; port i at bits [i*DW +: DW]
- rd_pending  out  NRD  pending bit of the register addressed by port i
- br_addr  in  AW  branch-target read address
- br_value  out  DW  branch-target read data
- wa_en  in  1  ALU write enable
- wa_addr  in  AW  ALU write address
- wa_data  in  DW  ALU write data
- wb_en  in  1  decode/load write enable; also clears pending
- wb_addr  in  AW  decode/load write address
- wb_data  in  DW  decode/load write data
- rsv_en  in  1  mark register rsv_addr pending
- rsv_addr  in  AW  register to reserve
- rsv_err  out  1  registered; 1 for one cycle after rsv_en hit an already-pending register
- any_pending  out  1  OR of all pending bits

## Operation
- Storage: NREG x DW data array plus NREG-bit pending vector.
- Reset (rst=1, asynchronous): all registers 0, all pending bits 0, rsv_err 0. Outputs follow: rd_data/br_value 0, rd_pending 0, any_pending 0.
- Reads: combinational from stored array. rd_pending[i] = pending[rd_addr port i]. Reads never alter state.
- Writes on rising edge:
  - wa_en alone: reg[wa_addr] <= wa_data.
  - wb_en alone: reg[wb_addr] <= wb_data; pending[wb_addr] <= 0.
  - Both with different addresses: both written.
  - Both with the same address: wa_data is stored (ALU wins). pending[wb_addr] still clears.
- Scoreboard:
  - rsv_en sets pending[rsv_addr] <= 1.
  - rsv_en and wb_en to the same address in the same cycle: pending ends 1 (reserve wins); data takes wb_data.
  - rsv_en to a register already pending: bit stays 1, and rsv_err=1 the next cycle.
  - wa_en does not affect pending.
- Out-of-range addresses do not exist (NREG is a power of two); all addresses are valid.

## Timing
- Read latency 0 cycles (combinational).
- Written data becomes visible on reads the cycle after the write edge, unless bypass is enabled.
- Pending set/clear becomes visible on rd_pending and any_pending the cycle after the edge.
- rsv_err is a single-cycle registered pulse, asserted the cycle after the offending rsv_en.
- Reset mid-operation discards in-flight writes and reservations; the first post-reset edge with writes behaves as a normal write.

## Configuration
- REGFILE_BYPASS_EN defined: each read port (general ports and br port) returns the write data when its address matches an active write port in the same cycle.
  - Priority: wa over wb, then stored value.
  - rd_pending is also bypassed: reads 0 when wb_en matches and no same-cycle rsv_en matches; reads 1 when rsv_en matches.
- Undefined: no bypass; reads always return stored state.

## Test plan
- Reset: drive rst=1 mid-run after writing 0xDEADBEEF to r3. Required: rd_data=0, any_pending=0 immediately (asynchronous), and still 0 after rst deasserts.
- Dual write: wa r1=0x11111111 and wb r2=0x22222222 in the same cycle, then read r1 and r2 next cycle. Required: 0x11111111 and 0x22222222. Then both ports target r5 (wa=0xAAAA0000, wb=0x0000BBBB). Required: r5 reads 0xAAAA0000.
- Scoreboard: rsv r4, then wait 3 cycles. Required: rd_pending for r4 =1, any_pending=1. Then wb r4=0x1234. Required: next cycle pending=0, data 0x1234, any_pending=0.
- Collisions: rsv r6 and wb r6=0x55 in the same cycle. Required: pending r6=1, data 0x55. Then rsv r6 again. Required: rsv_err=1 for exactly one cycle.
- Bypass (REGFILE_BYPASS_EN defined): wa r7=0x77 with rd_addr port0=r7 in the same cycle. Required: rd_data port0=0x77 that cycle. Without the macro: old value that cycle, 0x77 the next.
- Parameter sweep: DW=16, NREG=16, NRD=4. Write all 16 registers with value = index*0x0101, then read all four ports across the 16 addresses. Required: every read matches its written value.

Source files
------------

// File: rtl/regfile_param_if.sv
// Bus bundle for regfile_param: read ports, branch port, two write ports and scoreboard.
// The DUT connects through the slave modport, the driver through the master modport.
interface regfile_param_if #(
    parameter int DW  = 32,
    parameter int AW  = 3,
    parameter int NRD = 2
);
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD-1:0]    rd_pending;
    logic [AW-1:0]     br_addr;
    logic [DW-1:0]     br_value;
    logic              wa_en;
    logic [AW-1:0]     wa_addr;
    logic [DW-1:0]     wa_data;
    logic              wb_en;
    logic [AW-1:0]     wb_addr;
    logic [DW-1:0]     wb_data;
    logic              rsv_en;
    logic [AW-1:0]     rsv_addr;
    logic              rsv_err;
    logic              any_pending;

    modport master (
        output rd_addr, br_addr, wa_en, wa_addr, wa_data,
               wb_en, wb_addr, wb_data, rsv_en, rsv_addr,
        input  rd_data, rd_pending, br_value, rsv_err, any_pending
    );

    modport slave (
        input  rd_addr, br_addr, wa_en, wa_addr, wa_data,
               wb_en, wb_addr, wb_data, rsv_en, rsv_addr,
        output rd_data, rd_pending, br_value, rsv_err, any_pending
    );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file: NRD read ports + branch port, dual write, pending scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_param #(
    parameter int DW   = 32,
    parameter int NREG = 8,
    parameter int AW   = $clog2(NREG),
    parameter int NRD  = 2
) (
    input logic             clk,
    input logic             rst,
    regfile_param_if.slave  bus
);
    logic [DW-1:0]   regs_q [NREG];
    logic [DW-1:0]   regs_d [NREG];
    logic [NREG-1:0] pend_q, pend_d;
    logic            rsv_err_q, rsv_err_d;

    always_comb begin
        regs_d    = regs_q;
        pend_d    = pend_q;
        rsv_err_d = bus.rsv_en && pend_q[bus.rsv_addr];
        if (bus.wb_en) begin
            regs_d[bus.wb_addr] = bus.wb_data;
            pend_d[bus.wb_addr] = 1'b0;
        end
        // ALU port is applied last so it wins a same-address collision; reserve likewise wins over wb clear
        if (bus.wa_en) regs_d[bus.wa_addr] = bus.wa_data;
        if (bus.rsv_en) pend_d[bus.rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            pend_q    <= '0;
            rsv_err_q <= 1'b0;
        end else begin
            regs_q    <= regs_d;
            pend_q    <= pend_d;
            rsv_err_q <= rsv_err_d;
        end
    end

    logic [NRD*DW-1:0] rd_data_w;
    logic [NRD-1:0]    rd_pend_w;
    logic [DW-1:0]     br_w;

    // Port index NRD is the branch-target port; it shares the data path but has no pending output
    genvar gi;
    generate
        for (gi = 0; gi < NRD + 1; gi++) begin : g_port
            logic [AW-1:0] a;
            logic [DW-1:0] v;

            always_comb begin
                v = regs_q[a];
`ifdef REGFILE_BYPASS_EN
                if (bus.wa_en && bus.wa_addr == a)      v = bus.wa_data;
                else if (bus.wb_en && bus.wb_addr == a) v = bus.wb_data;
`endif
            end

            if (gi < NRD) begin : g_gen
                logic p;
                assign a = bus.rd_addr[gi*AW +: AW];
                always_comb begin
                    p = pend_q[a];
`ifdef REGFILE_BYPASS_EN
                    if (bus.rsv_en && bus.rsv_addr == a)    p = 1'b1;
                    else if (bus.wb_en && bus.wb_addr == a) p = 1'b0;
`endif
                end
                assign rd_data_w[gi*DW +: DW] = v;
                assign rd_pend_w[gi]          = p;
            end else begin : g_br
                assign a    = bus.br_addr;
                assign br_w = v;
            end
        end
    endgenerate

    assign bus.rd_data     = rd_data_w;
    assign bus.rd_pending  = rd_pend_w;
    assign bus.br_value    = br_w;
    assign bus.rsv_err     = rsv_err_q;
    assign bus.any_pending = |pend_q;
endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: directed steps, randomized traffic against a
// rule-level model, and a DW=16/NREG=16/NRD=4 sweep instance.
module tb_regfile_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_param_if #(.DW(32), .AW(3), .NRD(2)) s ();
    regfile_param_if #(.DW(16), .AW(4), .NRD(4)) b ();

    regfile_param #(.DW(32), .NREG(8), .NRD(2)) u_small (.clk(clk), .rst(rst), .bus(s.slave));
    regfile_param #(.DW(16), .NREG(16), .NRD(4)) u_big (.clk(clk), .rst(rst), .bus(b.slave));

    int vectors    = 0;
    int miscompares = 0;

    logic [31:0] m_regs [8];
    logic [7:0]  m_pend;
    logic        m_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_pend = '0;
        m_err  = 1'b0;
    endfunction

    // Applies the write/scoreboard rules for one rising edge using the inputs currently driven
    function automatic void model_update();
        m_err = s.rsv_en && m_pend[s.rsv_addr];
        if (s.wb_en) begin
            m_regs[s.wb_addr] = s.wb_data;
            m_pend[s.wb_addr] = 1'b0;
        end
        if (s.wa_en) m_regs[s.wa_addr] = s.wa_data;
        if (s.rsv_en) m_pend[s.rsv_addr] = 1'b1;
    endfunction

    function automatic logic [31:0] exp_data(input logic [2:0] a);
`ifdef REGFILE_BYPASS_EN
        if (s.wa_en && s.wa_addr == a) return s.wa_data;
        if (s.wb_en && s.wb_addr == a) return s.wb_data;
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_pend(input logic [2:0] a);
`ifdef REGFILE_BYPASS_EN
        if (s.rsv_en && s.rsv_addr == a) return 1'b1;
        if (s.wb_en && s.wb_addr == a) return 1'b0;
`endif
        return m_pend[a];
    endfunction

    task automatic idle();
        s.wa_en = 0; s.wa_addr = 0; s.wa_data = 0;
        s.wb_en = 0; s.wb_addr = 0; s.wb_data = 0;
        s.rsv_en = 0; s.rsv_addr = 0;
    endtask

    task automatic check_reads();
        logic [2:0] a;
        for (int p = 0; p < 2; p++) begin
            a = s.rd_addr[p*3 +: 3];
            check($sformatf("rd_data[%0d]@r%0d", p, a), 64'(s.rd_data[p*32 +: 32]), 64'(exp_data(a)));
            check($sformatf("rd_pending[%0d]@r%0d", p, a), 64'(s.rd_pending[p]), 64'(exp_pend(a)));
        end
        check("br_value", 64'(s.br_value), 64'(exp_data(s.br_addr)));
        check("any_pending", 64'(s.any_pending), 64'(|m_pend));
    endtask

    // Starts at posedge+1 with inputs driven; ends at the next posedge+1
    task automatic cycle();
        #4;
        check_reads();
        @(posedge clk);
        model_update();
        #1;
        check("rsv_err", 64'(s.rsv_err), 64'(m_err));
    endtask

    initial begin
        idle();
        s.rd_addr = '0; s.br_addr = '0;
        b.rd_addr = '0; b.br_addr = '0;
        b.wa_en = 0; b.wa_addr = 0; b.wa_data = 0;
        b.wb_en = 0; b.wb_addr = 0; b.wb_data = 0;
        b.rsv_en = 0; b.rsv_addr = 0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_rd_data", 64'(s.rd_data), 64'd0);
        check("reset_any_pending", 64'(s.any_pending), 64'd0);
        check("reset_rsv_err", 64'(s.rsv_err), 64'd0);
        rst = 1'b0;

        // Asynchronous reset mid-run
        s.wa_en = 1; s.wa_addr = 3; s.wa_data = 32'hDEADBEEF;
        s.rsv_en = 1; s.rsv_addr = 2;
        cycle();
        idle();
        s.rd_addr = {3'd2, 3'd3};
        #1;
        check("pre_reset_r3", 64'(s.rd_data[31:0]), 64'hDEADBEEF);
        check("pre_reset_any", 64'(s.any_pending), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check("async_reset_r3", 64'(s.rd_data[31:0]), 64'd0);
        check("async_reset_any", 64'(s.any_pending), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("post_reset_r3", 64'(s.rd_data[31:0]), 64'd0);
        check("post_reset_any", 64'(s.any_pending), 64'd0);
        cycle();

        // Dual write, distinct then same address
        s.wa_en = 1; s.wa_addr = 1; s.wa_data = 32'h11111111;
        s.wb_en = 1; s.wb_addr = 2; s.wb_data = 32'h22222222;
        cycle();
        idle();
        s.rd_addr = {3'd2, 3'd1};
        #1;
        check("dual_r1", 64'(s.rd_data[31:0]), 64'h11111111);
        check("dual_r2", 64'(s.rd_data[63:32]), 64'h22222222);
        s.wa_en = 1; s.wa_addr = 5; s.wa_data = 32'hAAAA0000;
        s.wb_en = 1; s.wb_addr = 5; s.wb_data = 32'h0000BBBB;
        cycle();
        idle();
        s.rd_addr = {3'd0, 3'd5};
        #1;
        check("same_addr_r5", 64'(s.rd_data[31:0]), 64'hAAAA0000);
        cycle();

        // Scoreboard reserve then clear via wb
        s.rsv_en = 1; s.rsv_addr = 4;
        cycle();
        idle();
        s.rd_addr = {3'd0, 3'd4};
        cycle(); cycle(); cycle();
        check("sb_pend_r4", 64'(s.rd_pending[0]), 64'd1);
        check("sb_any_set", 64'(s.any_pending), 64'd1);
        s.wb_en = 1; s.wb_addr = 4; s.wb_data = 32'h1234;
        cycle();
        idle();
        #1;
        check("sb_clear_pend", 64'(s.rd_pending[0]), 64'd0);
        check("sb_clear_data", 64'(s.rd_data[31:0]), 64'h1234);
        check("sb_clear_any", 64'(s.any_pending), 64'd0);
        cycle();

        // Reserve/wb collision, then double reserve
        s.rsv_en = 1; s.rsv_addr = 6;
        s.wb_en = 1; s.wb_addr = 6; s.wb_data = 32'h55;
        cycle();
        idle();
        s.rd_addr = {3'd0, 3'd6};
        #1;
        check("coll_pend_r6", 64'(s.rd_pending[0]), 64'd1);
        check("coll_data_r6", 64'(s.rd_data[31:0]), 64'h55);
        check("coll_no_err", 64'(s.rsv_err), 64'd0);
        s.rsv_en = 1; s.rsv_addr = 6;
        cycle();
        idle();
        check("dbl_rsv_err_set", 64'(s.rsv_err), 64'd1);
        cycle();
        check("dbl_rsv_err_clr", 64'(s.rsv_err), 64'd0);
        s.wb_en = 1; s.wb_addr = 6; s.wb_data = 32'h66;
        cycle();
        idle();

        // Same-cycle read of a write target
        s.rd_addr = {3'd0, 3'd7};
        s.wa_en = 1; s.wa_addr = 7; s.wa_data = 32'h77;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass_same_cycle", 64'(s.rd_data[31:0]), 64'h77);
`else
        check("nobypass_same_cycle", 64'(s.rd_data[31:0]), 64'(m_regs[7]));
`endif
        cycle();
        idle();
        #1;
        check("write_next_cycle", 64'(s.rd_data[31:0]), 64'h77);
        cycle();

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            s.wa_en    = 1'($urandom_range(0, 1));
            s.wa_addr  = 3'($urandom_range(0, 7));
            s.wa_data  = $urandom;
            s.wb_en    = 1'($urandom_range(0, 1));
            s.wb_addr  = 3'($urandom_range(0, 7));
            s.wb_data  = $urandom;
            s.rsv_en   = ($urandom_range(0, 2) == 0);
            s.rsv_addr = 3'($urandom_range(0, 7));
            s.rd_addr  = 6'($urandom);
            s.br_addr  = 3'($urandom);
            cycle();
        end
        idle();

        // Wide configuration sweep: two writes per cycle, then read across all ports
        for (int i = 0; i < 8; i++) begin
            b.wa_en = 1; b.wa_addr = 4'(2*i);     b.wa_data = 16'((2*i) * 16'h0101);
            b.wb_en = 1; b.wb_addr = 4'(2*i + 1); b.wb_data = 16'((2*i + 1) * 16'h0101);
            @(posedge clk);
            #1;
        end
        b.wa_en = 0; b.wb_en = 0;
        for (int a = 0; a < 16; a++) begin
            for (int p = 0; p < 4; p++) b.rd_addr[p*4 +: 4] = 4'((a + p) % 16);
            b.br_addr = 4'(15 - a);
            #1;
            for (int p = 0; p < 4; p++)
                check($sformatf("sweep_port%0d_r%0d", p, (a + p) % 16),
                      64'(b.rd_data[p*16 +: 16]), 64'(16'(((a + p) % 16) * 16'h0101)));
            check($sformatf("sweep_br_r%0d", 15 - a), 64'(b.br_value), 64'(16'((15 - a) * 16'h0101)));
        end
        check("sweep_any_pending", 64'(b.any_pending), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
